sd1306_rx: RTL and testbench

- Receive-side counterpart of our SSD1306 4-wire SPI display driver: a synthesizable SSD1306 display model.
- Samples the driver's SCLK/SDIN/CS/DC/RES pins and assembles bytes.
- Decodes the command stream into display state registers.
- Writes data bytes into a 1024-byte framebuffer write port using SSD1306 GDDRAM addressing.
- Used as a loopback checker on-board and as the bench model for the driver.

---
 rtl/sd1306_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_sd1306_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sd1306_rx.sv
// Receive-side SSD1306 4-wire SPI display model: samples the driver pins, assembles
// bytes, decodes the command stream into display state and emits GDDRAM writes.
module sd1306_rx #(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      spi_sclk,
  input  logic                                      spi_sdin,
  input  logic                                      spi_cs,
  input  logic                                      spi_dc,
  input  logic                                      spi_res,
  output logic                                      fb_we,
  output logic [$clog2(COLS)+$clog2(PAGES)-1:0]     fb_addr,
  output logic [7:0]                                fb_wdata,
  output logic                                      display_on,
  output logic [7:0]                                contrast,
  output logic                                      invert,
  output logic [1:0]                                addr_mode,
  output logic                                      charge_pump,
  output logic                                      frame_done
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_ARG1 = 2'd1,
    CMD_ARG2 = 2'd2
  } state_e;

  logic [1:0] sclk_sync_q, sdin_sync_q, cs_sync_q, dc_sync_q, res_sync_q;
  logic       sclk_dly_q;
  logic       sclk_s, sdin_s, cs_s, dc_s, rst_s, sclk_rise_s;

  // Synchronisers preset to the idle pin levels so release from reset makes no false edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= 2'b11;
      sdin_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      dc_sync_q   <= 2'b00;
      res_sync_q  <= 2'b11;
      sclk_dly_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
      sdin_sync_q <= {sdin_sync_q[0], spi_sdin};
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      dc_sync_q   <= {dc_sync_q[0], spi_dc};
      res_sync_q  <= {res_sync_q[0], spi_res};
      sclk_dly_q  <= sclk_sync_q[1];
    end
  end

  assign sclk_s      = sclk_sync_q[1];
  assign sdin_s      = sdin_sync_q[1];
  assign cs_s        = cs_sync_q[1];
  assign dc_s        = dc_sync_q[1];
  assign rst_s       = reset | ~res_sync_q[1];
  assign sclk_rise_s = sclk_s & ~sclk_dly_q;

  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] rx_byte_q;
  logic       rx_dc_q;
  logic       byte_valid_q;

  // Byte assembly; a deselect drops any partial byte
  always_ff @(posedge clk) begin
    if (rst_s) begin
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      rx_byte_q    <= 8'h00;
      rx_dc_q      <= 1'b0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (cs_s) begin
        bit_cnt_q <= 3'd0;
      end else if (sclk_rise_s) begin
        shift_q   <= {shift_q[5:0], sdin_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_q    <= {shift_q, sdin_s};
          rx_dc_q      <= dc_s;
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  state_e          state_q;
  logic [7:0]      opcode_q;
  logic [CW-1:0]   arg1_q;
  logic [CW-1:0]   col_q, col_start_q, col_end_q, col_d, col_inc_s;
  logic [PW-1:0]   page_q, page_start_q, page_end_q, page_d, page_inc_s;
  logic            col_last_s, page_last_s, wrap_s;
  logic            fb_we_q, frame_done_q, display_on_q, invert_q, charge_pump_q;
  logic [CW+PW-1:0] fb_addr_q;
  logic [7:0]      fb_wdata_q, contrast_q;
  logic [1:0]      addr_mode_q;

  // Next write pointer; ranges are matched by equality only, so start > end is legal
  always_comb begin
    col_last_s  = (col_q == col_end_q);
    page_last_s = (page_q == page_end_q);
    col_inc_s   = col_last_s ? col_start_q : col_q + CW'(1);
    page_inc_s  = page_last_s ? page_start_q : page_q + PW'(1);
    col_d       = col_q;
    page_d      = page_q;
    wrap_s      = 1'b0;
    case (addr_mode_q)
      2'd0: begin
        col_d = col_inc_s;
        if (col_last_s) begin
          page_d = page_inc_s;
          wrap_s = page_last_s;
        end else begin
          page_d = page_q;
          wrap_s = 1'b0;
        end
      end
      2'd1: begin
        page_d = page_inc_s;
        if (page_last_s) begin
          col_d  = col_inc_s;
          wrap_s = col_last_s;
        end else begin
          col_d  = col_q;
          wrap_s = 1'b0;
        end
      end
      default: begin
        col_d  = col_inc_s;
        page_d = page_q;
        wrap_s = 1'b0;
      end
    endcase
  end

  // Command decoder FSM and registered outputs; data bytes abort a pending command
  always_ff @(posedge clk) begin
    if (rst_s) begin
      state_q       <= CMD_IDLE;
      opcode_q      <= 8'h00;
      arg1_q        <= '0;
      col_q         <= '0;
      page_q        <= '0;
      col_start_q   <= '0;
      col_end_q     <= CW'(COLS - 1);
      page_start_q  <= '0;
      page_end_q    <= PW'(PAGES - 1);
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_wdata_q    <= 8'h00;
      frame_done_q  <= 1'b0;
      display_on_q  <= 1'b0;
      contrast_q    <= 8'h7F;
      invert_q      <= 1'b0;
      addr_mode_q   <= 2'b10;
      charge_pump_q <= 1'b0;
    end else begin
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (byte_valid_q) begin
        if (rx_dc_q) begin
          state_q      <= CMD_IDLE;
          fb_we_q      <= 1'b1;
          fb_addr_q    <= {page_q, col_q};
          fb_wdata_q   <= rx_byte_q;
          frame_done_q <= wrap_s;
          col_q        <= col_d;
          page_q       <= page_d;
        end else begin
          case (state_q)
            CMD_IDLE: begin
              opcode_q <= rx_byte_q;
              case (rx_byte_q)
                8'hAE: display_on_q <= 1'b0;
                8'hAF: display_on_q <= 1'b1;
                8'hA6: invert_q <= 1'b0;
                8'hA7: invert_q <= 1'b1;
                8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7:
                  page_q <= rx_byte_q[PW-1:0];
                8'h81, 8'h20, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h21, 8'h22:
                  state_q <= CMD_ARG1;
                default: state_q <= CMD_IDLE;
              endcase
            end
            CMD_ARG1: begin
              arg1_q  <= rx_byte_q[CW-1:0];
              state_q <= CMD_IDLE;
              case (opcode_q)
                8'h81: contrast_q <= rx_byte_q;
                8'h20: addr_mode_q <= rx_byte_q[1:0];
                8'h8D: charge_pump_q <= rx_byte_q[2];
                8'h21, 8'h22: state_q <= CMD_ARG2;
                default: state_q <= CMD_IDLE;
              endcase
            end
            CMD_ARG2: begin
              state_q <= CMD_IDLE;
              if (opcode_q == 8'h21) begin
                col_start_q <= arg1_q;
                col_end_q   <= rx_byte_q[CW-1:0];
                col_q       <= arg1_q;
              end else begin
                page_start_q <= arg1_q[PW-1:0];
                page_end_q   <= rx_byte_q[PW-1:0];
                page_q       <= arg1_q[PW-1:0];
              end
            end
            default: state_q <= CMD_IDLE;
          endcase
        end
      end
    end
  end

  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_wdata    = fb_wdata_q;
  assign frame_done  = frame_done_q;
  assign display_on  = display_on_q;
  assign contrast    = contrast_q;
  assign invert      = invert_q;
  assign addr_mode   = addr_mode_q;
  assign charge_pump = charge_pump_q;
endmodule

// File: tb/tb_sd1306_rx.sv
// Self-checking bench for sd1306_rx: drives SPI byte streams and scoreboards the
// framebuffer writes (address, data, frame_done, latency) plus the display state.
module tb_sd1306_rx;
  logic       clk = 1'b0;
  logic       reset, spi_sclk, spi_sdin, spi_cs, spi_dc, spi_res;
  logic       fb_we, display_on, invert, charge_pump, frame_done;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, contrast;
  logic [1:0] addr_mode;

  sd1306_rx dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_sdin(spi_sdin),
    .spi_cs(spi_cs), .spi_dc(spi_dc), .spi_res(spi_res),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .display_on(display_on), .contrast(contrast), .invert(invert),
    .addr_mode(addr_mode), .charge_pump(charge_pump), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int rise_cyc = 0;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    logic       fd;
    int         at;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  logic [7:0] init_seq [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40,
                                8'hA1, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
                                8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
  int win_addr [9] = '{272, 273, 274, 275, 400, 401, 402, 403, 272};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the top n bits of b, MSB first, with cs held low
  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    spi_cs = 1'b0;
    spi_dc = dc;
    for (int i = 0; i < n; i++) begin
      spi_sclk = 1'b0;
      spi_sdin = b[7-i];
      tick(2);
      spi_sclk = 1'b1;
      rise_cyc = cyc;
      tick(2);
    end
  endtask

  task automatic cmd(input logic [7:0] b);
    send_bits(b, 8, 1'b0);
    spi_cs = 1'b1;
    tick(3);
  endtask

  // Write lands 4 clk edges after the edge that raised sclk for the last bit
  task automatic data(input logic [7:0] b, input logic [9:0] a, input logic fd);
    wr_t e;
    send_bits(b, 8, 1'b1);
    e.addr = a;
    e.data = b;
    e.fd   = fd;
    e.at   = rise_cyc + 4;
    exp_q.push_back(e);
  endtask

  // Write monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'(fb_we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(fb_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(fb_wdata), 32'(mon_e.data));
        chk("wr_frame_done", 32'(frame_done), 32'(mon_e.fd));
        chk("wr_latency", 32'(cyc), 32'(mon_e.at));
      end
    end else if (frame_done !== 1'b0) begin
      chk("stray_frame_done", 32'(frame_done), 32'd0);
    end
  end

  initial begin
    reset = 1'b1; spi_sclk = 1'b1; spi_sdin = 1'b0; spi_cs = 1'b1; spi_dc = 1'b0; spi_res = 1'b1;
    tick(4);
    chk("rst_display_on", 32'(display_on), 32'd0);
    chk("rst_contrast", 32'(contrast), 32'h7F);
    chk("rst_addr_mode", 32'(addr_mode), 32'd2);
    chk("rst_invert", 32'(invert), 32'd0);
    chk("rst_charge_pump", 32'(charge_pump), 32'd0);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    reset = 1'b0;
    tick(4);

    foreach (init_seq[i]) cmd(init_seq[i]);
    tick(8);
    chk("init_display_on", 32'(display_on), 32'd1);
    chk("init_contrast", 32'(contrast), 32'h7F);
    chk("init_addr_mode", 32'(addr_mode), 32'd0);
    chk("init_charge_pump", 32'(charge_pump), 32'd1);
    chk("init_invert", 32'(invert), 32'd0);

    // Full frame in horizontal mode, then wrap to address 0
    for (int i = 0; i < 1024; i++) data(8'(i), 10'(i), (i == 1023));
    data(8'hAB, 10'd0, 1'b0);

    // Column window 0x10..0x13, pages 2..3
    cmd(8'h21); cmd(8'h10); cmd(8'h13);
    cmd(8'h22); cmd(8'h02); cmd(8'h03);
    for (int i = 0; i < 9; i++) data(8'hC0 + 8'(i), 10'(win_addr[i]), (i == 7));

    // Page mode
    cmd(8'h20); cmd(8'h02);
    cmd(8'h21); cmd(8'h00); cmd(8'h7F);
    cmd(8'hB5);
    data(8'h0A, 10'd640, 1'b0);
    data(8'h0B, 10'd641, 1'b0);
    cmd(8'h21); cmd(8'h7E); cmd(8'h7F);
    data(8'h11, 10'd766, 1'b0);
    data(8'h12, 10'd767, 1'b0);
    data(8'h13, 10'd766, 1'b0);
    tick(8);
    chk("page_addr_mode", 32'(addr_mode), 32'd2);

    // Partial byte dropped by deselect
    cmd(8'hAE);
    tick(8);
    chk("ae_display_on", 32'(display_on), 32'd0);
    send_bits(8'hFF, 5, 1'b1);
    spi_cs = 1'b1;
    tick(3);
    cmd(8'hAF);
    tick(8);
    chk("partial_display_on", 32'(display_on), 32'd1);

    // Data aborts a pending 81
    cmd(8'h81);
    data(8'h55, 10'd767, 1'b0);
    cmd(8'hA7);
    tick(8);
    chk("abort_contrast", 32'(contrast), 32'h7F);
    chk("abort_invert", 32'(invert), 32'd1);

    // reset mid-byte
    cmd(8'h81); cmd(8'h20);
    tick(8);
    chk("set_contrast", 32'(contrast), 32'h20);
    send_bits(8'hA5, 4, 1'b0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("rst2_contrast", 32'(contrast), 32'h7F);
    chk("rst2_addr_mode", 32'(addr_mode), 32'd2);
    chk("rst2_invert", 32'(invert), 32'd0);
    chk("rst2_display_on", 32'(display_on), 32'd0);
    cmd(8'hAF);
    tick(8);
    chk("rst2_post_cmd", 32'(display_on), 32'd1);
    data(8'h3C, 10'd0, 1'b0);

    // spi_res mid-byte
    cmd(8'h81); cmd(8'h20);
    cmd(8'h20); cmd(8'h00);
    tick(8);
    chk("set_contrast2", 32'(contrast), 32'h20);
    chk("set_mode0", 32'(addr_mode), 32'd0);
    send_bits(8'h5A, 3, 1'b0);
    spi_res = 1'b0;
    tick(4);
    spi_res = 1'b1;
    tick(4);
    chk("res_contrast", 32'(contrast), 32'h7F);
    chk("res_addr_mode", 32'(addr_mode), 32'd2);
    chk("res_charge_pump", 32'(charge_pump), 32'd0);
    data(8'h5A, 10'd0, 1'b0);
    cmd(8'hAF);
    tick(8);
    chk("res_post_cmd", 32'(display_on), 32'd1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
